// File: rtl/sym_fir_mc.sv
// sym_fir_mc: multi-channel symmetric FIR decimator for 1-bit bitstreams.
// Each channel's bit shifts into a TAPS-long delay line on every clock.
// A FILTER strobe snapshots every line. The block then folds one symmetric
// tap pair per clock against a loadable half-coefficient table, channel by
// channel, and emits one rounded sample per channel.
//
// Ports:
//   Clock, Reset_n        rising-edge clock, async active-low reset
//   BitIn[CHANNELS]       one sample bit per channel per clock
//   FILTER                compute request (dropped while Busy)
//   CoefWr/Addr/Data      half-table write h[k], honoured only in IDLE
//   Dout, Chan, Push      rounded signed sample, its channel, valid strobe
//   Busy                  FSM not IDLE
//   Overrun               one-cycle pulse when FILTER is dropped
//
// Option: define SYM_FIR_SATURATE_EN to clamp the rounded value to the
// OUT_W range instead of wrapping.

module sym_fir_mc #(
    parameter int TAPS     = 512,
    parameter int CHANNELS = 2,
    parameter int COEF_W   = 29,
    parameter int OUT_W    = 16,
    parameter int SHIFT    = 8
) (
    input  logic                              Clock,
    input  logic                              Reset_n,
    input  logic [CHANNELS-1:0]               BitIn,
    input  logic                              FILTER,
    input  logic                              CoefWr,
    input  logic [$clog2(TAPS/2)-1:0]         CoefAddr,
    input  logic signed [COEF_W-1:0]          CoefData,
    output logic [OUT_W-1:0]                  Dout,
    output logic [(CHANNELS>1 ? $clog2(CHANNELS) : 1)-1:0] Chan,
    output logic                              Push,
    output logic                              Busy,
    output logic                              Overrun
);

    localparam int HALF  = TAPS / 2;
    localparam int KW    = $clog2(HALF);
    localparam int TW    = $clog2(TAPS);
    localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int OCW   = $clog2(CHANNELS + 1);
    localparam int ACC_W = COEF_W + $clog2(TAPS) + 1;

    localparam logic signed [ACC_W:0] RND  = (ACC_W+1)'(2 ** (SHIFT - 1));
`ifdef SYM_FIR_SATURATE_EN
    localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [ACC_W:0] MINV = -MAXV - 1;
`endif

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        OUT
    } state_t;

    state_t state;

    logic [TAPS-1:0]          line [CHANNELS];
    logic [TAPS-1:0]          snap [CHANNELS];
    logic signed [COEF_W-1:0] h    [HALF];
    logic signed [ACC_W-1:0]  res  [CHANNELS];
    logic signed [ACC_W-1:0]  acc;
    logic [KW-1:0]            k;
    logic [CW-1:0]            ch;
    logic [OCW-1:0]           oc;

    // Tap-pair fold: s = lo + hi in 0..2, so the product is 0, h or 2h.
    logic                     b_lo;
    logic                     b_hi;
    logic [TW-1:0]            hi_idx;
    logic signed [ACC_W-1:0]  hx;
    logic signed [ACC_W-1:0]  term;
    logic signed [ACC_W-1:0]  acc_nx;

    always_comb begin
        hi_idx = TW'(TAPS - 1) - TW'(k);
        b_lo   = snap[ch][TW'(k)];
        b_hi   = snap[ch][hi_idx];
        hx     = ACC_W'(h[k]);
        term   = '0;
        if (b_lo && b_hi)
            term = hx <<< 1;
        else if (b_lo || b_hi)
            term = hx;
        acc_nx = acc + term;
    end

    // Output rounding: one extra bit keeps the +half from overflowing.
    logic signed [ACC_W-1:0] res_sel;
    logic signed [ACC_W:0]   rsum;
    logic signed [ACC_W:0]   rsh;
    logic [OUT_W-1:0]        dout_nx;

    always_comb begin
        res_sel = res[CW'(oc)];
        rsum    = {res_sel[ACC_W-1], res_sel} + RND;
        rsh     = rsum >>> SHIFT;
`ifdef SYM_FIR_SATURATE_EN
        if (rsh > MAXV)
            dout_nx = OUT_W'(MAXV);
        else if (rsh < MINV)
            dout_nx = OUT_W'(MINV);
        else
            dout_nx = OUT_W'(rsh);
`else
        dout_nx = OUT_W'(rsh);
`endif
    end

    // Coefficient table has no reset; writes are locked out while busy.
    always_ff @(posedge Clock) begin
        if (CoefWr && state == IDLE)
            h[CoefAddr] <= CoefData;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                line[c] <= '0;
                snap[c] <= '0;
                res[c]  <= '0;
            end
            state   <= IDLE;
            acc     <= '0;
            k       <= '0;
            ch      <= '0;
            oc      <= '0;
            Dout    <= '0;
            Chan    <= '0;
            Push    <= 1'b0;
            Busy    <= 1'b0;
            Overrun <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++)
                line[c] <= {line[c][TAPS-2:0], BitIn[c]};
            Push    <= 1'b0;
            Overrun <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (FILTER) begin
                        // Snapshot includes the bit entering on this edge.
                        for (int c = 0; c < CHANNELS; c++)
                            snap[c] <= {line[c][TAPS-2:0], BitIn[c]};
                        acc   <= '0;
                        k     <= '0;
                        ch    <= '0;
                        state <= CALC;
                        Busy  <= 1'b1;
                    end
                end
                CALC: begin
                    Overrun <= FILTER;
                    if (k == KW'(HALF - 1)) begin
                        res[ch] <= acc_nx;
                        acc     <= '0;
                        k       <= '0;
                        if (ch == CW'(CHANNELS - 1)) begin
                            oc    <= '0;
                            state <= OUT;
                        end else begin
                            ch <= ch + 1'b1;
                        end
                    end else begin
                        acc <= acc_nx;
                        k   <= k + 1'b1;
                    end
                end
                OUT: begin
                    Overrun <= FILTER;
                    if (oc == OCW'(CHANNELS)) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end else begin
                        Push <= 1'b1;
                        Chan <= CW'(oc);
                        Dout <= dout_nx;
                        oc   <= oc + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
